// File: rtl/alarm_core.sv
// ---------------------------------------------------------------------------
// alarm_core
//
// Alarm register and ring engine sitting behind the push-button controller.
// The controller's alarm pulses are edge-detected and decoded into an
// editable BCD HH:MM alarm time plus an armed flag.  The alarm time is then
// compared against the running BCD clock, and a timed ring is produced for
// the buzzer/LED and the LCD alarm indicator.
//
// Parameters
//   TICK_DIV      CLOCK_50 cycles per second of ring timing
//   RING_SECONDS  ring duration in seconds (>= 1)
//
// Ports
//   CLOCK_50      in   system clock, all logic on the rising edge
//   reset         in   synchronous active-high reset
//   adjust_alarm  in   level, high while the controller is in alarm-adjust
//   flip_state    in   toggle armed flag (rising edge, adjust only)
//   select_add    in   advance digit select (rising edge, adjust only)
//   alarm_add     in   increment selected digit (rising edge, adjust only)
//   alarm_clr     in   zero selected digit (rising edge, adjust only)
//   cur_time      in   running time {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}
//   alarm_time    out  alarm time {h_tens,h_ones,m_tens,m_ones}
//   alarm_on      out  alarm armed
//   sel           out  selected digit: 0 m_ones, 1 m_tens, 2 h_ones, 3 h_tens
//   ringing       out  alarm sounding
// ---------------------------------------------------------------------------
module alarm_core #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int RING_SECONDS = 60
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        adjust_alarm,
  input  logic        flip_state,
  input  logic        select_add,
  input  logic        alarm_add,
  input  logic        alarm_clr,
  input  logic [23:0] cur_time,
  output logic [15:0] alarm_time,
  output logic        alarm_on,
  output logic [1:0]  sel,
  output logic        ringing
);

  // A TICK_DIV of 1 would give a zero-width counter, so keep at least one bit.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = $clog2(RING_SECONDS + 1);

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [SEC_W-1:0]  SEC_LOAD  = SEC_W'(RING_SECONDS);
  localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } ring_state_t;

  // Edge-detect registers
  logic adj_q,     adj_d;
  logic flip_q,    flip_d;
  logic sel_add_q, sel_add_d;
  logic add_q,     add_d;
  logic clr_q,     clr_d;

  // Alarm register state
  logic [15:0] alarm_time_q, alarm_time_d;
  logic        alarm_on_q,   alarm_on_d;
  logic [1:0]  sel_q,        sel_d;

  // Ring engine state
  ring_state_t       state_q, state_d;
  logic              match_q, match_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [SEC_W-1:0]  secs_q,  secs_d;

  logic adj_rise, flip_ev, sel_ev, add_ev, clr_ev;
  logic match;

  logic [3:0]  h_tens, h_ones, m_tens, m_ones;
  logic [3:0]  new_h_tens, new_h_ones;
  logic [15:0] inc_time, clr_time;

  assign h_tens = alarm_time_q[15:12];
  assign h_ones = alarm_time_q[11:8];
  assign m_tens = alarm_time_q[7:4];
  assign m_ones = alarm_time_q[3:0];

  assign adj_rise = adjust_alarm & ~adj_q;
  assign flip_ev  = flip_state   & ~flip_q;
  assign sel_ev   = select_add   & ~sel_add_q;
  assign add_ev   = alarm_add    & ~add_q;
  assign clr_ev   = alarm_clr    & ~clr_q;

  assign match = (cur_time == {alarm_time_q, 8'h00});

  // Edge registers and the match history simply track their inputs.
  always_comb begin
    adj_d     = adjust_alarm;
    flip_d    = flip_state;
    sel_add_d = select_add;
    add_d     = alarm_add;
    clr_d     = alarm_clr;
    match_d   = match;
  end

  // Per-digit increment with independent wrap.  The hours digits keep the
  // value inside 00..23: h_ones stops at 3 when h_tens is 2, and moving
  // h_tens up to 2 pulls an out-of-range h_ones down to 3.
  always_comb begin
    inc_time   = alarm_time_q;
    new_h_tens = h_tens;
    new_h_ones = h_ones;
    case (sel_q)
      2'd0: inc_time[3:0] = (m_ones >= 4'd9) ? 4'd0 : m_ones + 4'd1;
      2'd1: inc_time[7:4] = (m_tens >= 4'd5) ? 4'd0 : m_tens + 4'd1;
      2'd2: begin
        if (h_tens == 4'd2) begin
          inc_time[11:8] = (h_ones >= 4'd3) ? 4'd0 : h_ones + 4'd1;
        end else begin
          inc_time[11:8] = (h_ones >= 4'd9) ? 4'd0 : h_ones + 4'd1;
        end
      end
      default: begin
        new_h_tens = (h_tens >= 4'd2) ? 4'd0 : h_tens + 4'd1;
        if ((new_h_tens == 4'd2) && (h_ones > 4'd3)) begin
          new_h_ones = 4'd3;
        end
        inc_time[15:12] = new_h_tens;
        inc_time[11:8]  = new_h_ones;
      end
    endcase
  end

  // Clearing touches only the selected digit.
  always_comb begin
    clr_time = alarm_time_q;
    case (sel_q)
      2'd0:    clr_time[3:0]   = 4'd0;
      2'd1:    clr_time[7:4]   = 4'd0;
      2'd2:    clr_time[11:8]  = 4'd0;
      default: clr_time[15:12] = 4'd0;
    endcase
  end

  // Edit decoder: only one event acts per cycle, flip first, then select,
  // then add, then clear.  Entering adjust always restarts at m_ones.
  always_comb begin
    alarm_time_d = alarm_time_q;
    alarm_on_d   = alarm_on_q;
    sel_d        = sel_q;
    if (adjust_alarm) begin
      if (flip_ev) begin
        alarm_on_d = ~alarm_on_q;
      end else if (sel_ev) begin
        sel_d = sel_q + 2'd1;
      end else if (add_ev) begin
        alarm_time_d = inc_time;
      end else if (clr_ev) begin
        alarm_time_d = clr_time;
      end
    end
    if (adj_rise) begin
      sel_d = 2'd0;
    end
  end

  // Ring FSM: start only on a fresh match edge while armed and not editing,
  // so a held match or an edit into the current time never rings.  The ring
  // ends on the last tick of the last second, on entering adjust, or as soon
  // as the alarm is disarmed.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    secs_d  = secs_q;
    case (state_q)
      IDLE: begin
        if (alarm_on_q && !adjust_alarm && match && !match_q) begin
          state_d = RING;
          tick_d  = '0;
          secs_d  = SEC_LOAD;
        end
      end
      default: begin
        if (tick_q == TICK_MAX) begin
          tick_d = '0;
          secs_d = secs_q - SEC_ONE;
          if (secs_q <= SEC_ONE) begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
        if (adj_rise || !alarm_on_d) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      adj_q        <= 1'b0;
      flip_q       <= 1'b0;
      sel_add_q    <= 1'b0;
      add_q        <= 1'b0;
      clr_q        <= 1'b0;
      alarm_time_q <= 16'h0000;
      alarm_on_q   <= 1'b0;
      sel_q        <= 2'd0;
      state_q      <= IDLE;
      match_q      <= 1'b0;
      tick_q       <= '0;
      secs_q       <= '0;
    end else begin
      adj_q        <= adj_d;
      flip_q       <= flip_d;
      sel_add_q    <= sel_add_d;
      add_q        <= add_d;
      clr_q        <= clr_d;
      alarm_time_q <= alarm_time_d;
      alarm_on_q   <= alarm_on_d;
      sel_q        <= sel_d;
      state_q      <= state_d;
      match_q      <= match_d;
      tick_q       <= tick_d;
      secs_q       <= secs_d;
    end
  end

  assign alarm_time = alarm_time_q;
  assign alarm_on   = alarm_on_q;
  assign sel        = sel_q;
  assign ringing    = (state_q == RING);

endmodule

// File: tb/tb_alarm_core.sv
// ---------------------------------------------------------------------------
// tb_alarm_core
//
// Directed bench for alarm_core with TICK_DIV = 4 and RING_SECONDS = 3.
// Stimulus changes inputs 1 time unit after a rising edge and, where a
// result is due, queues the hand-computed expected outputs.  A monitor on
// the falling edge pops each queued expectation and compares it with the
// DUT outputs.
// ---------------------------------------------------------------------------
module tb_alarm_core;

  localparam int TICK_DIV     = 4;
  localparam int RING_SECONDS = 3;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] ADJ  = 5'b10000;
  localparam logic [4:0] FLIP = 5'b01000;
  localparam logic [4:0] SEL  = 5'b00100;
  localparam logic [4:0] ADD  = 5'b00010;
  localparam logic [4:0] CLR  = 5'b00001;

  localparam logic [23:0] TIME_OTHER = 24'h123456;
  localparam logic [23:0] TIME_ALARM = 24'h070100;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        adjustAlarm;
  logic        flipState;
  logic        selectAdd;
  logic        alarmAdd;
  logic        alarmClr;
  logic [23:0] curTime;
  logic [15:0] alarmTime;
  logic        alarmOn;
  logic [1:0]  selOut;
  logic        ringing;

  typedef struct {
    string       name;
    logic [15:0] alarmTime;
    logic        alarmOn;
    logic [1:0]  sel;
    logic        ringing;
  } expect_t;

  expect_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  alarm_core #(
    .TICK_DIV    (TICK_DIV),
    .RING_SECONDS(RING_SECONDS)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .adjust_alarm(adjustAlarm),
    .flip_state  (flipState),
    .select_add  (selectAdd),
    .alarm_add   (alarmAdd),
    .alarm_clr   (alarmClr),
    .cur_time    (curTime),
    .alarm_time  (alarmTime),
    .alarm_on    (alarmOn),
    .sel         (selOut),
    .ringing     (ringing)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Drive the control inputs for one clock and return just after the edge.
  task automatic applyStimulus(input logic [4:0] vec);
    {adjustAlarm, flipState, selectAdd, alarmAdd, alarmClr} = vec;
    @(posedge CLOCK_50);
    #1;
  endtask

  // Press and release a button while holding the adjust level given.
  task automatic pulse(input logic [4:0] level, input logic [4:0] button);
    applyStimulus(level | button);
    applyStimulus(level);
  endtask

  // Queue the outputs expected after the edge just taken.
  task automatic checkOutput(input string name, input logic [15:0] expTime,
                             input logic expOn, input logic [1:0] expSel,
                             input logic expRing);
    expect_t e;
    e.name      = name;
    e.alarmTime = expTime;
    e.alarmOn   = expOn;
    e.sel       = expSel;
    e.ringing   = expRing;
    expQ.push_back(e);
  endtask

  // Monitor: outputs are registered, so they are stable on the falling edge.
  always @(negedge CLOCK_50) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      compared++;
      if (alarmTime !== e.alarmTime || alarmOn !== e.alarmOn ||
          selOut !== e.sel || ringing !== e.ringing) begin
        mismatched++;
        $display("[TB] FAIL %s: got time=%h on=%b sel=%0d ring=%b, want time=%h on=%b sel=%0d ring=%b",
                 e.name, alarmTime, alarmOn, selOut, ringing,
                 e.alarmTime, e.alarmOn, e.sel, e.ringing);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    curTime = TIME_OTHER;

    // Reset state
    applyStimulus(NONE);
    applyStimulus(NONE);
    checkOutput("reset", 16'h0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;

    // Enter adjust and build 0900 on h_ones
    applyStimulus(ADJ);
    checkOutput("adjEnter", 16'h0000, 1'b0, 2'd0, 1'b0);
    pulse(ADJ, SEL);
    pulse(ADJ, SEL);
    checkOutput("selTwo", 16'h0000, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 9; i++) pulse(ADJ, ADD);
    checkOutput("hOnesNine", 16'h0900, 1'b0, 2'd2, 1'b0);

    // Re-entering adjust restarts the select at m_ones
    applyStimulus(NONE);
    applyStimulus(ADJ);
    checkOutput("reenterSel0", 16'h0900, 1'b0, 2'd0, 1'b0);

    // Three selects reach h_tens, then walk 0900 -> 1900 -> 2300 -> 0300
    pulse(ADJ, SEL);
    pulse(ADJ, SEL);
    pulse(ADJ, SEL);
    checkOutput("selThree", 16'h0900, 1'b0, 2'd3, 1'b0);
    pulse(ADJ, ADD);
    checkOutput("hTensOne", 16'h1900, 1'b0, 2'd3, 1'b0);
    pulse(ADJ, ADD);
    checkOutput("clamp2300", 16'h2300, 1'b0, 2'd3, 1'b0);
    pulse(ADJ, ADD);
    checkOutput("wrap0300", 16'h0300, 1'b0, 2'd3, 1'b0);

    // Select wraps 3 -> 0; a held add gives exactly one increment
    pulse(ADJ, SEL);
    checkOutput("selWrap", 16'h0300, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(ADJ | ADD);
    applyStimulus(ADJ);
    checkOutput("heldAdd", 16'h0301, 1'b0, 2'd0, 1'b0);

    // Clear only the selected digit
    pulse(ADJ, SEL);
    pulse(ADJ, SEL);
    pulse(ADJ, CLR);
    checkOutput("clrHOnes", 16'h0001, 1'b0, 2'd2, 1'b0);
    pulse(ADJ, SEL);
    pulse(ADJ, SEL);
    pulse(ADJ, CLR);
    pulse(ADJ, SEL);
    checkOutput("prioSetup", 16'h0000, 1'b0, 2'd1, 1'b0);

    // Same-cycle priority
    applyStimulus(ADJ | SEL | ADD);
    checkOutput("prioSelOverAdd", 16'h0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(ADJ);
    applyStimulus(ADJ | FLIP | SEL);
    checkOutput("prioFlipOverSel", 16'h0000, 1'b1, 2'd2, 1'b0);
    applyStimulus(ADJ);

    // Events outside adjust are ignored
    applyStimulus(NONE);
    pulse(NONE, ADD);
    pulse(NONE, FLIP);
    pulse(NONE, CLR);
    checkOutput("gated", 16'h0000, 1'b1, 2'd2, 1'b0);

    // Program 0701
    applyStimulus(ADJ);
    pulse(ADJ, ADD);
    pulse(ADJ, SEL);
    pulse(ADJ, SEL);
    for (int i = 0; i < 7; i++) pulse(ADJ, ADD);
    checkOutput("set0701", 16'h0701, 1'b1, 2'd2, 1'b0);
    applyStimulus(NONE);

    // Ring for exactly 3 x 4 cycles, no retrigger on held match
    curTime = TIME_ALARM;
    for (int i = 0; i < TICK_DIV * RING_SECONDS; i++) begin
      applyStimulus(NONE);
      checkOutput("ringOn", 16'h0701, 1'b1, 2'd2, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(NONE);
      checkOutput("ringOffHeld", 16'h0701, 1'b1, 2'd2, 1'b0);
    end

    // Abort by entering adjust; leaving adjust on a held match stays quiet
    curTime = TIME_OTHER;
    applyStimulus(NONE);
    curTime = TIME_ALARM;
    applyStimulus(NONE);
    checkOutput("ring2Start", 16'h0701, 1'b1, 2'd2, 1'b1);
    applyStimulus(NONE);
    applyStimulus(ADJ);
    checkOutput("abortAdj", 16'h0701, 1'b1, 2'd0, 1'b0);
    applyStimulus(NONE);
    checkOutput("noRingAfterAdj", 16'h0701, 1'b1, 2'd0, 1'b0);

    // Disarm during a ring
    curTime = TIME_OTHER;
    applyStimulus(NONE);
    curTime = TIME_ALARM;
    applyStimulus(NONE);
    checkOutput("ring3Start", 16'h0701, 1'b1, 2'd0, 1'b1);
    applyStimulus(ADJ | FLIP);
    checkOutput("flipOff", 16'h0701, 1'b0, 2'd0, 1'b0);
    applyStimulus(ADJ);

    // Editing into the current time while adjusting never rings
    pulse(ADJ, FLIP);
    pulse(ADJ, CLR);
    checkOutput("editAway", 16'h0700, 1'b1, 2'd0, 1'b0);
    pulse(ADJ, ADD);
    checkOutput("editIntoMatch", 16'h0701, 1'b1, 2'd0, 1'b0);
    applyStimulus(NONE);
    applyStimulus(NONE);
    checkOutput("leaveAdjNoRing", 16'h0701, 1'b1, 2'd0, 1'b0);

    // Reset in the middle of a ring
    curTime = TIME_OTHER;
    applyStimulus(NONE);
    curTime = TIME_ALARM;
    applyStimulus(NONE);
    checkOutput("ring4Start", 16'h0701, 1'b1, 2'd0, 1'b1);
    applyStimulus(NONE);
    reset = 1'b1;
    applyStimulus(NONE);
    checkOutput("resetMidRing", 16'h0000, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(NONE);
    checkOutput("afterReset", 16'h0000, 1'b0, 2'd0, 1'b0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
